// File: rtl/branch_target_predictor_if.sv
// Bundle for the branch target predictor.
// The pipeline side uses the master modport, and the predictor uses the slave modport.
//   Fetch:   PCF -> PredTakenF, PredTargetF
//   Control: StallD, FlushD, StallE, FlushE
//   Resolve: PCE, BranchTypeE, BranchE, BrNPC -> MispredictE, RecoverPC
//   Stats:   BrCount, MispCount
interface branch_target_predictor_if;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        StallD;
  logic        FlushD;
  logic        StallE;
  logic        FlushE;
  logic [31:0] PCE;
  logic [2:0]  BranchTypeE;
  logic        BranchE;
  logic [31:0] BrNPC;
  logic        MispredictE;
  logic [31:0] RecoverPC;
  logic [31:0] BrCount;
  logic [31:0] MispCount;

  modport master (
    output PCF, StallD, FlushD, StallE, FlushE, PCE, BranchTypeE, BranchE, BrNPC,
    input  PredTakenF, PredTargetF, MispredictE, RecoverPC, BrCount, MispCount
  );

  modport slave (
    input  PCF, StallD, FlushD, StallE, FlushE, PCE, BranchTypeE, BranchE, BrNPC,
    output PredTakenF, PredTargetF, MispredictE, RecoverPC, BrCount, MispCount
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// The fetch lookup predicts the next PC for PCF. Each prediction travels through ID and EX
// in a shadow register. In EX the prediction is resolved against the actual branch outcome.
// Ports:
//   clk   - single clock; all state changes on the rising edge
//   rst_n - asynchronous, active-low reset
//   bus   - slave side of branch_target_predictor_if, which carries fetch lookup,
//           stall/flush control, EX resolve inputs, mispredict/recover outputs and statistics
module branch_target_predictor #(
  parameter int unsigned IDX_W = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  branch_target_predictor_if.slave  bus
);
  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned TAG_W   = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] validMem;
  logic [TAG_W-1:0]   tagMem    [ENTRIES];
  logic [31:0]        targetMem [ENTRIES];
  logic [1:0]         ctrMem    [ENTRIES];

  logic [IDX_W-1:0] fIdx, eIdx;
  logic [TAG_W-1:0] fTag, eTag;
  logic             fHit, eHit;
  logic             predTakenF;
  logic [31:0]      predTargetF;

  logic        predTakenD, predTakenE;
  logic [31:0] predTargetD, predTargetE;

  logic        isBr, updEn, mispredict;
  logic [1:0]  ctrNext;
  logic [31:0] brCount, mispCount;

  assign fIdx = bus.PCF[IDX_W+1:2];
  assign fTag = bus.PCF[31:IDX_W+2];
  assign eIdx = bus.PCE[IDX_W+1:2];
  assign eTag = bus.PCE[31:IDX_W+2];

  // The fetch lookup reads only registered state.
  // A write at this edge therefore becomes visible to fetch from the next cycle.
  always_comb begin
    fHit        = validMem[fIdx] && (tagMem[fIdx] == fTag);
    predTakenF  = fHit && ctrMem[fIdx][1];
    predTargetF = predTakenF ? targetMem[fIdx] : '0;
  end

  always_comb begin
    isBr  = (bus.BranchTypeE != '0);
    updEn = isBr && !bus.StallE;
    eHit  = validMem[eIdx] && (tagMem[eIdx] == eTag);
    if (isBr)
      mispredict = (predTakenE != bus.BranchE) ||
                   (predTakenE && bus.BranchE && (predTargetE != bus.BrNPC));
    else
      mispredict = predTakenE;
    ctrNext = ctrMem[eIdx];
    if (bus.BranchE) begin
      if (ctrMem[eIdx] != 2'b11) ctrNext = ctrMem[eIdx] + 2'b01;
    end else begin
      if (ctrMem[eIdx] != 2'b00) ctrNext = ctrMem[eIdx] - 2'b01;
    end
  end

  // Prediction shadows follow the segment-register rule: stall holds, then flush clears.
  // FlushE does not gate updEn. The branch leaving EX still trains the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predTakenD  <= 1'b0;
      predTargetD <= '0;
      predTakenE  <= 1'b0;
      predTargetE <= '0;
    end else begin
      if (!bus.StallD) begin
        if (bus.FlushD) begin
          predTakenD  <= 1'b0;
          predTargetD <= '0;
        end else begin
          predTakenD  <= predTakenF;
          predTargetD <= predTargetF;
        end
      end
      if (!bus.StallE) begin
        if (bus.FlushE) begin
          predTakenE  <= 1'b0;
          predTargetE <= '0;
        end else begin
          predTakenE  <= predTakenD;
          predTargetE <= predTargetD;
        end
      end
    end
  end

  // Valid bits, counters and statistics are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validMem  <= '0;
      ctrMem    <= '{default: 2'b01};
      brCount   <= '0;
      mispCount <= '0;
    end else if (updEn) begin
      brCount   <= brCount + 32'd1;
      mispCount <= mispCount + {31'd0, mispredict};
      if (eHit) begin
        ctrMem[eIdx] <= ctrNext;
      end else if (bus.BranchE) begin
        validMem[eIdx] <= 1'b1;
        ctrMem[eIdx]   <= 2'b10;
      end
    end
  end

  // Tag and target contents are qualified by validMem, so they need no reset.
  always_ff @(posedge clk) begin
    if (updEn && bus.BranchE) begin
      tagMem[eIdx]    <= eTag;
      targetMem[eIdx] <= bus.BrNPC;
    end
  end

  assign bus.PredTakenF  = predTakenF;
  assign bus.PredTargetF = predTargetF;
  assign bus.MispredictE = mispredict;
  assign bus.RecoverPC   = (isBr && bus.BranchE) ? bus.BrNPC : bus.PCE + 32'd4;
  assign bus.BrCount     = brCount;
  assign bus.MispCount   = mispCount;
endmodule
